// File: rtl/readout_pkg.sv
// Shared types and constants for the readout serial transmitter.
package readout_pkg;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_START,
    RS_DATA,
    RS_PARITY
  } rs_state_t;

  localparam int unsigned FRAME_OVH = 2;

endpackage

// File: rtl/readout_fifo2.sv
// Two-entry FIFO between the input handshake and the frame shifter.
module readout_fifo2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/readout_serializer.sv
// Readout serial transmitter: buffers up to two parallel words and sends
// each as a frame of start bit, data MSB first, and even parity.
module readout_serializer
  import readout_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sframe,
  output logic             busy
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);

  rs_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic             par;
  logic [BW-1:0]    bit_cnt;
  logic             line_active;
  logic             div_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             push;
  logic             pop;

  assign din_ready = !fifo_full;
  assign push      = din_valid && din_ready;
  assign pop       = !fifo_empty &&
                     ((state == RS_IDLE) || ((state == RS_PARITY) && div_last));
  assign busy      = !fifo_empty || (state != RS_IDLE) || line_active;

  readout_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  generate
    if (DIV > 1) begin : g_div
      localparam int unsigned DW = $clog2(DIV);
      localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
      logic [DW-1:0] div_cnt;

      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          div_cnt <= '0;
        end else if ((state == RS_IDLE) || (div_cnt == DIV_MAX)) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      assign div_last = (div_cnt == DIV_MAX);
    end else begin : g_nodiv
      assign div_last = 1'b1;
    end
  endgenerate

  // Line outputs are registered from the current state, so the visible frame
  // trails the FSM by one cycle while keeping back-to-back frames contiguous.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= RS_IDLE;
      shreg       <= '0;
      par         <= 1'b0;
      bit_cnt     <= '0;
      sdo         <= 1'b0;
      sframe      <= 1'b0;
      line_active <= 1'b0;
    end else begin
      unique case (state)
        RS_IDLE: begin
          sdo         <= 1'b0;
          sframe      <= 1'b0;
          line_active <= 1'b0;
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            par   <= ^fifo_dout;
            state <= RS_START;
          end
        end
        RS_START: begin
          sdo         <= 1'b1;
          sframe      <= 1'b1;
          line_active <= 1'b1;
          if (div_last) begin
            bit_cnt <= BIT_MAX;
            state   <= RS_DATA;
          end
        end
        RS_DATA: begin
          sdo         <= shreg[WIDTH-1];
          sframe      <= 1'b0;
          line_active <= 1'b1;
          if (div_last) begin
            if (bit_cnt == '0) begin
              state <= RS_PARITY;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
            end
          end
        end
        RS_PARITY: begin
          sdo         <= par;
          sframe      <= 1'b0;
          line_active <= 1'b1;
          if (div_last) begin
            if (!fifo_empty) begin
              shreg <= fifo_dout;
              par   <= ^fifo_dout;
              state <= RS_START;
            end else begin
              state <= RS_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_serializer.sv
// Randomized and directed bench for readout_serializer at DIV=1 and DIV=3.
module tb_readout_serializer;
  import readout_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic [1:0]   din_ready_w;
  logic [1:0]   sdo_w;
  logic [1:0]   sframe_w;
  logic [1:0]   busy_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : m
    localparam int unsigned D = (g == 0) ? 1 : 3;
    localparam int L = (W + FRAME_OVH) * D;

    readout_serializer #(.WIDTH(W), .DIV(D)) u_dut (
      .clk       (clk),
      .rstb      (rstb),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready_w[g]),
      .sdo       (sdo_w[g]),
      .sframe    (sframe_w[g]),
      .busy      (busy_w[g])
    );

    // Each accepted word owns the output window [start, start+L); start is
    // two cycles after acceptance or right after the previous frame.
    int           cyc = 0;
    int           n_acc = 0;
    int           last_end = 0;
    logic [W-1:0] wq[$];
    int           sq[$];
    logic         exp_ready = 1'b1;

    always @(posedge clk or negedge rstb) begin
      int s;
      if (!rstb) begin
        wq.delete();
        sq.delete();
        last_end  = 0;
        exp_ready = 1'b1;
      end else begin
        cyc++;
        if (din_valid && exp_ready) begin
          s = (cyc + 2 > last_end) ? cyc + 2 : last_end;
          wq.push_back(din);
          sq.push_back(s);
          last_end = s + L;
          n_acc++;
        end
      end
    end

    always @(negedge clk) begin
      int cnt;
      int p;
      logic [W-1:0] w;
      logic e_sdo, e_sf, e_busy;
      e_sdo = 1'b0;
      e_sf = 1'b0;
      e_busy = 1'b0;
      cnt = 0;
      if (rstb) begin
        while (sq.size() > 0 && sq[0] + L <= cyc) begin
          void'(sq.pop_front());
          void'(wq.pop_front());
        end
        e_busy = (sq.size() > 0);
        foreach (sq[i]) begin
          if (sq[i] - 1 > cyc) cnt++;
          if (cyc >= sq[i]) begin
            w = wq[i];
            p = (cyc - sq[i]) / D;
            e_sf = (p == 0);
            if (p == 0) e_sdo = 1'b1;
            else if (p <= W) e_sdo = w[W - p];
            else e_sdo = ^w;
          end
        end
      end
      exp_ready = (cnt < 2);
      check($sformatf("sdo[%0d]@%0d", g, cyc), sdo_w[g], e_sdo);
      check($sformatf("sframe[%0d]@%0d", g, cyc), sframe_w[g], e_sf);
      check($sformatf("busy[%0d]@%0d", g, cyc), busy_w[g], e_busy);
      check($sformatf("din_ready[%0d]@%0d", g, cyc), din_ready_w[g], exp_ready);
    end
  end

  task automatic push1(input logic [W-1:0] w);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic push_at(input logic [W-1:0] w, input int target);
    for (int t = 0; t < 200 && m[0].cyc != target - 1; t++) @(negedge clk);
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic capture(input int g, input int n, output logic [63:0] bits,
                         output logic [63:0] sfv, output int st);
    bit seen;
    seen = 1'b0;
    bits = '0;
    sfv = '0;
    st = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sframe_w[g]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("frame_start_timeout", sframe_w[g], 1);
      return;
    end
    st = m[0].cyc;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bits = {bits[62:0], sdo_w[g]};
      sfv  = {sfv[62:0], sframe_w[g]};
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 600 && busy_w != 2'b00; t++) @(negedge clk);
    @(negedge clk);
    check("idle_timeout", busy_w, 2'b00);
  endtask

  logic [63:0] bits;
  logic [63:0] sfv;
  int          st;
  int          k;
  int          idx;
  int          a0;
  bit          saw_stall;
  logic [W-1:0] words [4];

  initial begin
    #12;
    check("rst_sdo", sdo_w, 2'b00);
    check("rst_sframe", sframe_w, 2'b00);
    check("rst_busy", busy_w, 2'b00);
    check("rst_ready", din_ready_w, 2'b11);
    @(negedge clk);
    #3 rstb = 1'b1;
    repeat (3) @(negedge clk);

    push1(16'hA5C3);
    k = m[0].cyc;
    capture(0, 18, bits, sfv, st);
    check("single_latency", st - k, 2);
    check("single_bits", bits[17:0], {1'b1, 16'hA5C3, 1'b0});
    check("single_sframe", sfv[17:0], 18'b1 << 17);
    wait_idle();

    push1(16'h0001);
    push1(16'hFFFF);
    capture(0, 36, bits, sfv, st);
    check("b2b_bits", bits[35:0], {1'b1, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0});
    check("b2b_sframe", sfv[35:0], {1'b1, 17'b0, 1'b1, 17'b0});
    wait_idle();

    words = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'h8001};
    saw_stall = 1'b0;
    fork
      begin
        idx = 0;
        a0 = m[0].n_acc;
        for (int t = 0; t < 300 && idx < 4; t++) begin
          @(negedge clk);
          if (!din_ready_w[0]) saw_stall = 1'b1;
          din = words[idx];
          din_valid = 1'b1;
          @(posedge clk);
          #1;
          if (m[0].n_acc != a0) begin
            idx++;
            a0 = m[0].n_acc;
          end
        end
        din_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          capture(0, 18, bits, sfv, st);
          check($sformatf("bp_word%0d", i), bits[16:1], words[i]);
        end
      end
    join
    check("bp_accepted", idx, 4);
    check("bp_stall", saw_stall, 1'b1);
    wait_idle();

    push1(16'h8000);
    capture(1, 54, bits, sfv, st);
    check("div3_bits", bits[53:0], {6'b111111, 45'b0, 3'b111});
    check("div3_sframe", sfv[53:0], {3'b111, 51'b0});
    wait_idle();

    push1(16'h1111);
    k = m[0].cyc;
    push_at(16'h2222, k + 2);
    push_at(16'h3333, k + 19);
    check("pushpop_ready", din_ready_w[0], 1'b1);
    capture(0, 18, bits, sfv, st);
    check("pushpop_contig", st, k + 20);
    check("pushpop_older", bits[17:0], {1'b1, 16'h2222, 1'b0});
    capture(0, 18, bits, sfv, st);
    check("pushpop_newer", bits[17:0], {1'b1, 16'h3333, 1'b0});
    wait_idle();

    push1(16'hFFFF);
    capture(0, 1, bits, sfv, st);
    repeat (6) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check("midrst_sdo", sdo_w, 2'b00);
    check("midrst_sframe", sframe_w, 2'b00);
    check("midrst_busy", busy_w, 2'b00);
    check("midrst_ready", din_ready_w, 2'b11);
    repeat (2) @(negedge clk);
    #3 rstb = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("postrst_line", {sdo_w, sframe_w}, 4'b0000);
    end

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      din = W'($urandom);
      din_valid = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    din_valid = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
